// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller: the FSM state
// encoding, the hard-wired zero register index, and the width of the
// load-use bubble counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Remaining load-use bubbles; LOAD_LAT is limited to 1..7.
  localparam int unsigned LU_CNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (count -> 0)
//   inc    increment request for this cycle
//   clr    synchronous clear; takes precedence over inc
//   count  current count value
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1'b1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
// Stall/flush controller for a 5-stage pipeline. Detects load-use hazards
// between the instruction in ID and a load in EX, holds the back end while
// data memory is busy (with a timeout into a sticky error state), and
// flushes IF-ID on taken branches/jumps.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_id_rs, if_id_rt              ID source registers
//   id_ex_memRead, id_ex_rt         EX load flag and destination register
//   branch_taken, jump              control transfer resolved in ID
//   ex_mem_memAccess, dmem_ready    MEM stage access and completion
//   stall_cnt_clr                   synchronous clear of stall_count
//   pc_write, if_id_write           PC / IF-ID enables
//   if_id_flush, id_ex_bubble       zero IF-ID / inject NOP into ID-EX
//   pipe_hold                       freeze EX-MEM and MEM-WB
//   stall_count                     saturating count of pc_write=0 cycles
//   mem_err                         sticky memory timeout flag
//   state_o                         current FSM state
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_ex_memRead,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_mem_memAccess,
  input  logic             dmem_ready,
  input  logic             stall_cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err,
  output logic [1:0]       state_o
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [LU_CNT_W-1:0] LU_INIT   = LU_CNT_W'(LOAD_LAT - 1);

  state_t              r_state,    w_state_nxt;
  logic [LU_CNT_W-1:0] r_lu_cnt,   w_lu_cnt_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic                r_mem_err,  w_mem_err_nxt;

  logic w_load_use;
  logic w_mem_busy;
  logic w_cf;

  assign w_load_use = id_ex_memRead && (id_ex_rt != REG_ZERO) &&
                      ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign w_mem_busy = ex_mem_memAccess && !dmem_ready;
  assign w_cf       = branch_taken || jump;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_lu_cnt   <= '0;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lu_cnt   <= w_lu_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  // Next-state logic. r_lu_cnt is left untouched while in MEM_WAIT so an
  // interrupted load-use stall resumes with the bubbles it still owed.
  always_comb begin
    w_state_nxt    = r_state;
    w_lu_cnt_nxt   = r_lu_cnt;
    w_wait_cnt_nxt = '0;
    w_mem_err_nxt  = r_mem_err;
    unique case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_state_nxt = MEM_WAIT;
        end else if (w_load_use && (LOAD_LAT > 1)) begin
          w_state_nxt  = LU_STALL;
          w_lu_cnt_nxt = LU_INIT;
        end
      end
      LU_STALL: begin
        if (w_mem_busy) begin
          w_state_nxt = MEM_WAIT;
        end else if (r_lu_cnt <= LU_CNT_W'(1)) begin
          w_state_nxt  = RUN;
          w_lu_cnt_nxt = '0;
        end else begin
          w_lu_cnt_nxt = r_lu_cnt - LU_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (w_mem_busy) begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt   = ERR;
            w_mem_err_nxt = 1'b1;
            w_lu_cnt_nxt  = '0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_state_nxt = (r_lu_cnt != '0) ? LU_STALL : RUN;
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Output logic: combinational from registered state and current inputs.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            pipe_hold = 1'b1;
          end else if (w_load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = w_cf;
          end
        end
        LU_STALL: begin
          if (w_mem_busy) begin
            pipe_hold = 1'b1;
          end else begin
            id_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (w_mem_busy) begin
            pipe_hold = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        ERR: begin
          pipe_hold    = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: begin
          pipe_hold = 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .clr   (stall_cnt_clr),
    .count (stall_count)
  );

  assign mem_err = r_mem_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
// Directed bench for hazard_controller. Two instances share all inputs:
// u_a (LOAD_LAT=3, MEM_TIMEOUT=8, CNT_W=4) and u_b (LOAD_LAT=1, defaults).
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       id_ex_memRead, branch_taken, jump;
  logic       ex_mem_memAccess, dmem_ready, stall_cnt_clr;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_pipe_hold;
  logic [3:0]  a_stall_count;
  logic        a_mem_err;
  logic [1:0]  a_state_o;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_pipe_hold;
  logic [15:0] b_stall_count;
  logic        b_mem_err;
  logic [1:0]  b_state_o;

  logic [4:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_pipe_hold};
  assign b_ctl = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_pipe_hold};

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  localparam logic [4:0] C_RST   = 5'b00000;
  localparam logic [4:0] C_IDLE  = 5'b11000;
  localparam logic [4:0] C_FLUSH = 5'b11100;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_ERR   = 5'b00011;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .LOAD_LAT    (3),
    .MEM_TIMEOUT (8),
    .CNT_W       (4)
  ) u_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .id_ex_memRead    (id_ex_memRead),
    .id_ex_rt         (id_ex_rt),
    .branch_taken     (branch_taken),
    .jump             (jump),
    .ex_mem_memAccess (ex_mem_memAccess),
    .dmem_ready       (dmem_ready),
    .stall_cnt_clr    (stall_cnt_clr),
    .pc_write         (a_pc_write),
    .if_id_write      (a_if_id_write),
    .if_id_flush      (a_if_id_flush),
    .id_ex_bubble     (a_id_ex_bubble),
    .pipe_hold        (a_pipe_hold),
    .stall_count      (a_stall_count),
    .mem_err          (a_mem_err),
    .state_o          (a_state_o)
  );

  hazard_controller #(
    .LOAD_LAT    (1),
    .MEM_TIMEOUT (64),
    .CNT_W       (16)
  ) u_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .id_ex_memRead    (id_ex_memRead),
    .id_ex_rt         (id_ex_rt),
    .branch_taken     (branch_taken),
    .jump             (jump),
    .ex_mem_memAccess (ex_mem_memAccess),
    .dmem_ready       (dmem_ready),
    .stall_cnt_clr    (stall_cnt_clr),
    .pc_write         (b_pc_write),
    .if_id_write      (b_if_id_write),
    .if_id_flush      (b_if_id_flush),
    .id_ex_bubble     (b_id_ex_bubble),
    .pipe_hold        (b_pipe_hold),
    .stall_count      (b_stall_count),
    .mem_err          (b_mem_err),
    .state_o          (b_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [4:0] ctl, input logic [1:0] st);
    chk({tag, " A.ctl"}, 32'(a_ctl), 32'(ctl));
    chk({tag, " A.state"}, 32'(a_state_o), 32'(st));
  endtask

  task automatic chk_b(input string tag, input logic [4:0] ctl, input logic [1:0] st);
    chk({tag, " B.ctl"}, 32'(b_ctl), 32'(ctl));
    chk({tag, " B.state"}, 32'(b_state_o), 32'(st));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
    id_ex_memRead = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    ex_mem_memAccess = 1'b0; dmem_ready = 1'b1; stall_cnt_clr = 1'b0;

    // Reset state
    #2;
    chk_a("rst", C_RST, 2'd0);
    chk_b("rst", C_RST, 2'd0);
    chk("rst A.cnt", 32'(a_stall_count), 32'd0);
    chk("rst A.err", 32'(a_mem_err), 32'd0);
    chk("rst B.err", 32'(b_mem_err), 32'd0);
    tick(); tick();
    chk_a("rst_clk", C_RST, 2'd0);
    chk("rst_clk A.cnt", 32'(a_stall_count), 32'd0);

    rst_n = 1'b1;
    #1;
    chk_a("idle", C_IDLE, 2'd0);
    chk_b("idle", C_IDLE, 2'd0);
    tick();

    // Load into r0 never stalls
    id_ex_memRead = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    #1;
    chk_a("r0", C_IDLE, 2'd0);
    chk_b("r0", C_IDLE, 2'd0);
    chk("r0 A.cnt", 32'(a_stall_count), 32'd0);
    tick();

    // Load-use on rs: B one bubble, A three bubbles (state 0,1,1,0)
    id_ex_rt = 5'd5; if_id_rs = 5'd5;
    #1;
    chk_a("lu0", C_STALL, 2'd0);
    chk_b("lu0", C_STALL, 2'd0);
    tick();
    id_ex_memRead = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    #1;
    chk_a("lu1", C_STALL, 2'd1);
    chk_b("lu1", C_IDLE, 2'd0);
    chk("lu1 B.cnt", 32'(b_stall_count), 32'd1);
    chk("lu1 A.cnt", 32'(a_stall_count), 32'd1);
    tick();
    chk_a("lu2", C_STALL, 2'd1);
    chk("lu2 A.cnt", 32'(a_stall_count), 32'd2);
    tick();
    chk_a("lu3", C_IDLE, 2'd0);
    chk("lu3 A.cnt", 32'(a_stall_count), 32'd3);
    chk("lu3 B.cnt", 32'(b_stall_count), 32'd1);
    tick();

    // Branch with load-use on rt: bubble only; flush once the hazard clears
    id_ex_memRead = 1'b1; id_ex_rt = 5'd7; if_id_rt = 5'd7; branch_taken = 1'b1;
    #1;
    chk_a("brlu", C_STALL, 2'd0);
    chk_b("brlu", C_STALL, 2'd0);
    tick();
    id_ex_memRead = 1'b0; id_ex_rt = 5'd0; if_id_rt = 5'd0;
    #1;
    chk_b("br", C_FLUSH, 2'd0);
    chk_a("br", C_STALL, 2'd1);
    chk("br B.cnt", 32'(b_stall_count), 32'd2);
    chk("br A.cnt", 32'(a_stall_count), 32'd4);
    tick();
    branch_taken = 1'b0;
    #1;
    chk_a("lu_c1", C_STALL, 2'd1);
    chk("lu_c1 A.cnt", 32'(a_stall_count), 32'd5);

    // Memory busy 4 cycles while A still owes one bubble
    ex_mem_memAccess = 1'b1; dmem_ready = 1'b0;
    #1;
    chk_a("mb0", C_HOLD, 2'd1);
    chk_b("mb0", C_HOLD, 2'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_a("mbw", C_HOLD, 2'd2);
      chk_b("mbw", C_HOLD, 2'd2);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk_a("mbr", C_IDLE, 2'd2);
    chk_b("mbr", C_IDLE, 2'd2);
    chk("mbr A.cnt", 32'(a_stall_count), 32'd9);
    chk("mbr B.cnt", 32'(b_stall_count), 32'd6);
    tick();
    chk_a("resume", C_STALL, 2'd1);
    chk_b("resume", C_IDLE, 2'd0);
    tick();
    chk_a("resumed", C_IDLE, 2'd0);
    chk("resumed A.cnt", 32'(a_stall_count), 32'd10);
    ex_mem_memAccess = 1'b0;

    // Clear wins over increment; jump ignored while A stalls
    id_ex_memRead = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd9; stall_cnt_clr = 1'b1;
    #1;
    chk_a("clr", C_STALL, 2'd0);
    tick();
    stall_cnt_clr = 1'b0; id_ex_memRead = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    jump = 1'b1;
    #1;
    chk("clr A.cnt", 32'(a_stall_count), 32'd0);
    chk("clr B.cnt", 32'(b_stall_count), 32'd0);
    chk_a("jmp", C_STALL, 2'd1);
    chk_b("jmp", C_FLUSH, 2'd0);
    tick();
    jump = 1'b0;
    #1;
    chk_a("jmp2", C_STALL, 2'd1);
    chk("jmp2 A.cnt", 32'(a_stall_count), 32'd1);
    chk("jmp2 B.cnt", 32'(b_stall_count), 32'd0);
    tick();
    chk_a("idle2", C_IDLE, 2'd0);
    chk("idle2 A.cnt", 32'(a_stall_count), 32'd2);

    // Memory timeout: A errors after 8 wait cycles, B keeps waiting
    ex_mem_memAccess = 1'b1; dmem_ready = 1'b0;
    #1;
    chk_a("to0", C_HOLD, 2'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_a("tow", C_HOLD, 2'd2);
      chk("tow A.err", 32'(a_mem_err), 32'd0);
      tick();
    end
    chk_a("err", C_ERR, 2'd3);
    chk("err A.err", 32'(a_mem_err), 32'd1);
    chk("err A.cnt", 32'(a_stall_count), 32'd11);
    chk_b("to", C_HOLD, 2'd2);
    chk("to B.err", 32'(b_mem_err), 32'd0);
    ex_mem_memAccess = 1'b0; dmem_ready = 1'b1;
    #1;
    chk_a("err_sticky", C_ERR, 2'd3);
    chk_b("b_ready", C_IDLE, 2'd2);
    tick();
    chk_b("b_run", C_IDLE, 2'd0);
    chk("b_run B.cnt", 32'(b_stall_count), 32'd9);
    chk("err2 A.cnt", 32'(a_stall_count), 32'd12);
    repeat (5) tick();
    chk("sat A.cnt", 32'(a_stall_count), 32'd15);
    chk_a("err3", C_ERR, 2'd3);
    chk("err3 A.err", 32'(a_mem_err), 32'd1);

    // Reset clears ERR and mem_err
    rst_n = 1'b0;
    #1;
    chk_a("rst2", C_RST, 2'd0);
    chk("rst2 A.cnt", 32'(a_stall_count), 32'd0);
    chk("rst2 A.err", 32'(a_mem_err), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_a("rel2", C_IDLE, 2'd0);

    // Reset mid load-use stall discards remaining bubbles
    id_ex_memRead = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    tick();
    id_ex_memRead = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    #1;
    chk_a("midlu", C_STALL, 2'd1);
    rst_n = 1'b0;
    #1;
    chk_a("midrst", C_RST, 2'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_a("rel3", C_IDLE, 2'd0);
    chk("rel3 A.cnt", 32'(a_stall_count), 32'd0);
    tick();
    chk_a("rel4", C_IDLE, 2'd0);
    chk("rel4 A.cnt", 32'(a_stall_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
